// File: rtl/rtc_pkg.sv
// Shared definitions for the time-set controller.
//   state_t  : FSM state encoding (IDLE, SET_HR, SET_MIN, SET_SEC)
//   FLD_*    : codes driven on the field output for the display blinker
//   HR_MAX / MS_MAX : highest legal two-digit value for hours / min-sec
//   bcd2_t   : one two-digit BCD field
//   bcd_inc  : increments a two-digit BCD field with wrap to 00
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_HR   = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;
  localparam logic [1:0] FLD_SEC  = 2'b11;

  localparam logic [7:0] HR_MAX = 8'd23;
  localparam logic [7:0] MS_MAX = 8'd59;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } bcd2_t;

  // Anything at or above the limit (including captured illegal values)
  // wraps to 00; otherwise the low digit rolls 9 -> 0 into the high digit.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [7:0] max);
    logic [7:0] bin;
    bin = 8'(v.hi) * 8'd10 + 8'(v.lo);
    if (bin >= max)
      return '0;
    else if (v.lo >= 4'd9)
      return '{hi: v.hi + 4'd1, lo: 4'd0};
    else
      return '{hi: v.hi, lo: v.lo + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bus between the time-set controller and its surroundings.
//   btn_mode, btn_inc : raw bouncing buttons (active-high)
//   cur_*             : live BCD time from the timekeeping counter
//   set_*             : edited BCD time (shadow registers)
//   load              : one-cycle pulse, counter copies set_* on it
//   set_active        : high while editing; counter holds its count
//   field             : field under edit (FLD_* codes)
// master = environment (buttons, counter, display); slave = controller.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hrm, cur_hrl, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l;
  logic [3:0] set_hrm, set_hrl, set_min_m, set_min_l, set_sec_m, set_sec_l;
  logic       load;
  logic       set_active;
  logic [1:0] field;

  modport master (
    output btn_mode, btn_inc,
    output cur_hrm, cur_hrl, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l,
    input  set_hrm, set_hrl, set_min_m, set_min_l, set_sec_m, set_sec_l,
    input  load, set_active, field
  );

  modport slave (
    input  btn_mode, btn_inc,
    input  cur_hrm, cur_hrl, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l,
    output set_hrm, set_hrl, set_min_m, set_min_l, set_sec_m, set_sec_l,
    output load, set_active, field
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer, press pulse.
//   clk, rst : system clock, asynchronous active-high reset
//   btn_raw  : raw asynchronous bouncing button
//   press    : one-cycle pulse on each accepted 0->1 of the debounced level
// The debounced level follows the synchronized input only after it has
// differed for DEB_CYCLES consecutive cycles; any reversal restarts.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a, sync_b;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample the values from
  // before the edge; blocking = would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: MODE walks IDLE -> SET_HR -> SET_MIN -> SET_SEC ->
// IDLE, INC bumps the field being edited, and leaving SET_SEC issues LOAD.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : time_set_ctrl_if.slave (buttons, live time, edited time,
//              load, set_active, field)
module time_set_ctrl
  import rtc_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  time_set_ctrl_if.slave   bus
);

  logic   mode_press, inc_press;
  state_t state;
  bcd2_t  sh_hr, sh_min, sh_sec;
  logic   load, set_active;
  logic [1:0] field;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_mode),
    .press   (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_inc),
    .press   (inc_press)
  );

  // set_active and field are updated in the same branch as state so the
  // display and counter see them change on exactly the state edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh_hr      <= '0;
      sh_min     <= '0;
      sh_sec     <= '0;
      load       <= 1'b0;
      set_active <= 1'b0;
      field      <= FLD_NONE;
    end else begin
      load <= 1'b0;
      if (mode_press) begin
        // MODE wins over a coincident INC.
        unique case (state)
          IDLE: begin
            sh_hr      <= {bus.cur_hrm, bus.cur_hrl};
            sh_min     <= {bus.cur_min_m, bus.cur_min_l};
            sh_sec     <= {bus.cur_sec_m, bus.cur_sec_l};
            state      <= SET_HR;
            set_active <= 1'b1;
            field      <= FLD_HR;
          end
          SET_HR: begin
            state <= SET_MIN;
            field <= FLD_MIN;
          end
          SET_MIN: begin
            state <= SET_SEC;
            field <= FLD_SEC;
          end
          SET_SEC: begin
            state      <= IDLE;
            set_active <= 1'b0;
            field      <= FLD_NONE;
            load       <= 1'b1;
          end
        endcase
      end else if (inc_press) begin
        unique case (state)
          IDLE:    ;
          SET_HR:  sh_hr  <= bcd_inc(sh_hr, HR_MAX);
          SET_MIN: sh_min <= bcd_inc(sh_min, MS_MAX);
          SET_SEC: sh_sec <= bcd_inc(sh_sec, MS_MAX);
        endcase
      end
    end
  end

  assign bus.set_hrm    = sh_hr.hi;
  assign bus.set_hrl    = sh_hr.lo;
  assign bus.set_min_m  = sh_min.hi;
  assign bus.set_min_l  = sh_min.lo;
  assign bus.set_sec_m  = sh_sec.hi;
  assign bus.set_sec_l  = sh_sec.lo;
  assign bus.load       = load;
  assign bus.set_active = set_active;
  assign bus.field      = field;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with DEB_CYCLES = 4. A reference model holds the
// edit position (0 idle, 1 hours, 2 minutes, 3 seconds) and the three
// edited fields as plain decimal numbers.
module tb_time_set_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int m_pos;
  int m_val [3];
  int m_cur [3];
  int exp_loads;

  // load observer
  int         load_cycles = 0;
  logic [1:0] load_field  = 2'b11;
  logic       load_active = 1'b1;

  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      load_cycles++;
      load_field  = bus.field;
      load_active = bus.set_active;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    m_cur[0] = h; m_cur[1] = m; m_cur[2] = s;
    bus.cur_hrm   = 4'(h / 10); bus.cur_hrl   = 4'(h % 10);
    bus.cur_min_m = 4'(m / 10); bus.cur_min_l = 4'(m % 10);
    bus.cur_sec_m = 4'(s / 10); bus.cur_sec_l = 4'(s % 10);
  endtask

  task automatic model_reset();
    m_pos = 0;
    for (int i = 0; i < 3; i++) m_val[i] = 0;
  endtask

  task automatic model_mode();
    if (m_pos == 0) begin
      for (int i = 0; i < 3; i++) m_val[i] = m_cur[i];
      m_pos = 1;
    end else if (m_pos == 3) begin
      m_pos = 0;
      exp_loads++;
    end else begin
      m_pos++;
    end
  endtask

  task automatic model_inc();
    int lim;
    if (m_pos != 0) begin
      lim = (m_pos == 1) ? 23 : 59;
      if (m_val[m_pos-1] >= lim) m_val[m_pos-1] = 0;
      else                       m_val[m_pos-1] = m_val[m_pos-1] + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":field"},      bus.field, m_pos);
    chk({tag, ":set_active"}, bus.set_active, (m_pos != 0) ? 1 : 0);
    chk({tag, ":hrm"},  bus.set_hrm,   m_val[0] / 10);
    chk({tag, ":hrl"},  bus.set_hrl,   m_val[0] % 10);
    chk({tag, ":minm"}, bus.set_min_m, m_val[1] / 10);
    chk({tag, ":minl"}, bus.set_min_l, m_val[1] % 10);
    chk({tag, ":secm"}, bus.set_sec_m, m_val[2] / 10);
    chk({tag, ":secl"}, bus.set_sec_l, m_val[2] % 10);
    chk({tag, ":loads"}, load_cycles, exp_loads);
  endtask

  // Hold the buttons long enough to be accepted, then release and let the
  // release settle; the model is updated by the caller.
  task automatic press(input logic mode, input logic inc);
    @(negedge clk);
    bus.btn_mode = mode;
    bus.btn_inc  = inc;
    repeat (10) @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_press(input string tag, input logic mode, input logic inc);
    press(mode, inc);
    if (mode) model_mode();
    else if (inc) model_inc();
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    exp_loads = 0;
    set_cur(0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_model("reset");

    // Bounce: runs of 2 cycles never reach the 4-cycle acceptance.
    set_cur(12, 34, 56);
    for (int t = 0; t < 10; t++) begin
      bus.btn_mode = ~bus.btn_mode;
      repeat (2) @(negedge clk);
    end
    bus.btn_mode = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("bounce_press@%0d", k), dut.u_mode_deb.press, (k == 7) ? 1 : 0);
      if (k < 8) chk($sformatf("bounce_field@%0d", k), bus.field, 0);
    end
    model_mode();
    check_model("bounce_entry");
    repeat (10) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check_model("bounce_single");

    // Capture and commit; live time changes must not leak into the shadow.
    set_cur(1, 2, 3);
    @(negedge clk);
    check_model("no_track_hr");
    do_press("commit_min", 1'b1, 1'b0);
    do_press("commit_sec", 1'b1, 1'b0);
    do_press("commit_idle", 1'b1, 1'b0);
    chk("load_field", load_field, 0);
    chk("load_active", load_active, 0);
    set_cur(7, 8, 9);
    repeat (3) @(negedge clk);
    check_model("idle_hold");

    // Wrap cases, INC in idle ignored.
    set_cur(22, 9, 59);
    do_press("inc_idle", 1'b0, 1'b1);
    do_press("wrap_enter", 1'b1, 1'b0);
    do_press("hr_23", 1'b0, 1'b1);
    do_press("hr_00", 1'b0, 1'b1);
    do_press("to_min", 1'b1, 1'b0);
    do_press("min_10", 1'b0, 1'b1);
    do_press("to_sec", 1'b1, 1'b0);
    do_press("sec_00", 1'b0, 1'b1);

    // Simultaneous MODE and INC in SET_MIN.
    do_press("sim_idle", 1'b1, 1'b0);
    do_press("sim_hr", 1'b1, 1'b0);
    do_press("sim_min", 1'b1, 1'b0);
    do_press("sim_both", 1'b1, 1'b1);

    // Reset mid-edit: abandon without LOAD.
    do_press("edit_sec", 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("mid_reset");
    repeat (10) @(negedge clk);
    check_model("mid_reset_later");

    // Random operations, with occasionally illegal captured values.
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (m_pos == 0)
        set_cur($urandom_range(0, 2) * 10 + $urandom_range(0, 9),
                $urandom_range(0, 6) * 10 + $urandom_range(0, 9),
                $urandom_range(0, 6) * 10 + $urandom_range(0, 9));
      if (op < 3)      do_press($sformatf("rnd%0d_mode", n), 1'b1, 1'b0);
      else if (op < 9) do_press($sformatf("rnd%0d_inc", n), 1'b0, 1'b1);
      else             do_press($sformatf("rnd%0d_both", n), 1'b1, 1'b1);
    end

    // Button already held when reset is released still gets accepted.
    set_cur(5, 6, 7);
    @(negedge clk);
    bus.btn_mode = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("held_reset");
    repeat (12) @(negedge clk);
    model_mode();
    check_model("held_accept");
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check_model("held_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, number of consecutive stable CLK cycles required before a button level is accepted.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 BTN_MODE  input  1  raw, asynchronous, bouncing mode button; active-high.
REQ-005 BTN_INC  input  1  raw, asynchronous, bouncing increment button; active-high.
REQ-006 CUR_HRM, CUR_HRL, CUR_MIN_M, CUR_MIN_L, CUR_SEC_M, CUR_SEC_L  input  4 each  live BCD time from the timekeeping counter.
REQ-007 SET_HRM, SET_HRL, SET_MIN_M, SET_MIN_L, SET_SEC_M, SET_SEC_L  output  4 each  edited BCD time (shadow registers).
REQ-008 LOAD  output  1  one-cycle pulse; the counter copies the SET_* values on this pulse.
REQ-009 SET_ACTIVE  output  1  high while any set state is active; the counter holds its count while this is high.
REQ-010 FIELD  output  2  field under edit: 00 none, 01 hours, 10 minutes, 11 seconds; the display uses it to blink digits.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a debouncer.
REQ-012 The debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any reversal restarts the count.
REQ-013 A one-cycle press pulse fires on each 0->1 transition of the debounced level; releasing the button generates no pulse.
REQ-014 The FSM has states IDLE, SET_HR, SET_MIN and SET_SEC; every transition occurs on the CLK edge after the press pulse.
REQ-015 IDLE + MODE pulse: copy all six CUR_* values into the shadow registers, then go to SET_HR.
REQ-016 SET_HR + MODE pulse goes to SET_MIN; SET_MIN + MODE pulse goes to SET_SEC.
REQ-017 SET_SEC + MODE pulse: go to IDLE and assert LOAD for exactly one cycle, coincident with entry to IDLE.
REQ-018 An INC pulse in IDLE is ignored.
REQ-019 An INC pulse in a set state increments only that state's BCD field, as a single two-digit value.
REQ-020 Hours wrap 23 -> 00, with the low digit rolling 9 -> 0 into the high digit (09 -> 10, 19 -> 20).
REQ-021 Minutes and seconds wrap 59 -> 00, with the same low-digit roll-over rule.
REQ-022 If MODE and INC pulses occur in the same cycle, MODE is taken and INC is discarded.
REQ-023 Shadow registers are held in IDLE; they do not track CUR_* except on the capture in REQ-015.
REQ-024 SET_ACTIVE is 1 in SET_HR, SET_MIN and SET_SEC, and 0 in IDLE.
REQ-025 FIELD is 01, 10 and 11 in SET_HR, SET_MIN and SET_SEC respectively, and 00 in IDLE.
REQ-026 SET_ACTIVE and FIELD are registered and change in the same cycle as the state.
REQ-027 Illegal CUR_* BCD values captured on entry are not corrected; the first INC applies the wrap rule to values at or above the maximum, setting the field to 00.

Reset
REQ-028 RST forces the FSM to IDLE, all shadow registers to 0, LOAD and SET_ACTIVE to 0, and FIELD to 00.
REQ-029 RST also forces synchronizers, debounced levels and debounce counters to 0.
REQ-030 RST asserted mid-edit abandons the edit without issuing LOAD.
REQ-031 After reset deassertion, a button already held high produces a press pulse once it has been stable for DEB_CYCLES cycles.

Structure
REQ-032 A shared package rtc_pkg holds the FSM state encoding, the FIELD codes (FLD_NONE, FLD_HR, FLD_MIN, FLD_SEC) and the BCD limit constants HR_MAX = 23 and MS_MAX = 59.
REQ-033 The synchronizer, debouncer and rising-edge pulse are one sub-module, btn_debounce, instantiated twice.

Verification (DEB_CYCLES = 4)
REQ-034 Bounce test: BTN_MODE toggles every 2 cycles for 20 cycles, then is held high -> exactly one press pulse, 2 + 4 + 1 cycles after the final rise; the FSM is in SET_HR and FIELD = 01.
REQ-035 Capture and commit: CUR = 12:34:56, then MODE pressed three times -> SET_* reads 12:34:56 throughout, one LOAD pulse on return to IDLE, SET_ACTIVE then 0.
REQ-036 Wrap: in SET_HR from 22, press INC twice -> 23 then 00.
REQ-037 Wrap: in SET_MIN from 09, press INC once -> 10; in SET_SEC from 59, press INC once -> 00; other fields unchanged.
REQ-038 Simultaneous press: in SET_MIN, force MODE and INC pulses in the same cycle -> state becomes SET_SEC and minutes are unchanged.
REQ-039 Reset mid-edit: in SET_SEC with edited values, assert RST for 1 cycle -> IDLE, all outputs 0, no LOAD pulse at any point.
